shift_seq: RTL and testbench

Multi-cycle shift sequencer for the ALU path.
- Accepts one operand and a 5-bit shift amount.
- Applies one single-bit shift step per clock until the amount is used up, then presents the result with a one-cycle ready pulse.
- Serves as a low-area alternative to the full barrel shifter; it sits beside the ALU and is started by the same control decode that issues ALU ops.

---
 rtl/shift_seq_pkg.sv | 21 ++
 rtl/shift_seq_shift1_step.sv | 32 +++
 rtl/shift_seq.sv | 81 ++++++++
 tb/tb_shift_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the multi-cycle shift sequencer.
// SHIFT_SEQ_SRA_EN (optional define) enables the arithmetic-right operation.
// Holds the FSM state enum, op encodings and default widths.
package shift_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation encodings for the op input
  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

  // Default datapath sizing; 2**DEF_SHAMT_W must equal DEF_WIDTH
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

endpackage

// File: rtl/shift_seq_shift1_step.sv
// Combinational single-bit shift of a WIDTH-bit word: SLL, or SRA when enabled.
// Zero latency; no flow control.
// SHIFT_SEQ_SRA_EN selects whether the right-shift path exists at all.
module shift1_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             op_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] sll_d;

  // Logical left by one; the top bit falls off
  assign sll_d = {din_i[WIDTH-2:0], 1'b0};

`ifdef SHIFT_SEQ_SRA_EN
  logic [WIDTH-1:0] sra_d;

  // Arithmetic right by one; the sign bit is replicated
  assign sra_d  = {din_i[WIDTH-1], din_i[WIDTH-1:1]};
  assign dout_o = (op_i == OP_SRA) ? sra_d : sll_d;
`else
  // Right shift not built: op and the discarded top bit are deliberately unused
  logic unused_sig;
  assign unused_sig = op_i ^ din_i[WIDTH-1];
  assign dout_o     = sll_d;
`endif

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shifter: one single-bit step per clock, result with a one-cycle ready pulse.
// Latency shamt+1 cycles from strobe to ready; a new start is accepted in the DONE cycle.
// Starts are ignored while busy (SHIFT); SHIFT_SEQ_SRA_EN enables arithmetic right shifts.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_shift,
  input  logic               op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_resultRDY,
  output logic               busy
);

  state_t             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               op_q;
  logic [WIDTH-1:0]   acc_d;
  logic               op_d;

`ifdef SHIFT_SEQ_SRA_EN
  assign op_d = op;
`else
  // Every operation is SLL; the op port stays for interface compatibility
  logic unused_op;
  assign unused_op = op;
  assign op_d      = OP_SLL;
`endif

  shift1_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .op_i   (op_q),
    .din_i  (acc_q),
    .dout_o (acc_d)
  );

  // FSM plus operand/count registers; a start is only sampled in IDLE or DONE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (ctrl_shift) begin
            acc_q   <= data_in;
            cnt_q   <= shamt;
            op_q    <= op_d;
            state_q <= (shamt == '0) ? DONE : SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decoded straight from registered state; acc holds the result after DONE
  assign data_out       = acc_q;
  assign busy           = (state_q == SHIFT);
  assign data_resultRDY = (state_q == DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: scoreboard of expected results and ready cycles.
// Expected values come from a behavioural shift model in the bench.
// Covers reset, SLL, zero shift, SRA/maximum shift, handshake and reset abort.
module tb_shift_seq;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ctrl_shift = 1'b0;
  logic          op = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [SW-1:0] shamt = '0;
  logic [W-1:0]  data_out;
  logic          data_resultRDY;
  logic          busy;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  shift_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .op             (op),
    .data_in        (data_in),
    .shamt          (shamt),
    .data_out       (data_out),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s, input logic o);
    logic [W-1:0] r;
    r = d << s;
`ifdef SHIFT_SEQ_SRA_EN
    if (o) r = W'($signed(d) >>> s);
`endif
    return r;
  endfunction

  // Scoreboard: every ready pulse must match the oldest outstanding start
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_ready: data_out=%h at cycle %0d, no operation outstanding", data_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_out !== e.data || cyc != e.cyc) begin
          bad = bad + 1;
          $display("FAIL result: got data=%h cycle=%0d, expected data=%h cycle=%0d",
                   data_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  // Drive a one-cycle strobe just after a falling edge; returns at the next falling edge
  task automatic start(input logic [W-1:0] d, input int s, input logic o);
    exp_t e;
    @(negedge clock);
    ctrl_shift = 1'b1;
    data_in    = d;
    shamt      = SW'(s);
    op         = o;
    e.data     = model(d, s, o);
    e.cyc      = cyc + 1 + s;
    exp_q.push_back(e);
    @(negedge clock);
    ctrl_shift = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL timeout: %0d results outstanding after %0d cycles, expected 0", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    total = total + 3;
    if (data_out !== '0) begin bad++; $display("FAIL reset_data: got %h expected 0", data_out); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b expected 0", data_resultRDY); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_sll();
    start(32'h0000_0001, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total = total + 1;
      if (busy !== 1'b1) begin bad++; $display("FAIL sll_busy: cycle %0d busy=%b expected 1", i, busy); end
      @(negedge clock);
    end
    total = total + 1;
    if (busy !== 1'b0 || data_resultRDY !== 1'b1) begin
      bad++;
      $display("FAIL sll_ready: busy=%b rdy=%b expected busy=0 rdy=1", busy, data_resultRDY);
    end
    wait_done();
  endtask

  task automatic test_zero();
    start(32'hDEAD_BEEF, 0, 1'b0);
    total = total + 1;
    if (busy !== 1'b0 || data_resultRDY !== 1'b1 || data_out !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL zero_shift: busy=%b rdy=%b data=%h expected 0 1 deadbeef", busy, data_resultRDY, data_out);
    end
    wait_done();
  endtask

  task automatic test_sra();
    start(32'h8000_0000, 31, 1'b1);
    wait_done();
    start(32'hF000_00F0, 3, 1'b1);
    wait_done();
  endtask

  task automatic test_max_sll();
    start(32'hFFFF_FFFF, 31, 1'b0);
    wait_done();
    total = total + 1;
    if (data_out !== 32'h8000_0000) begin
      bad++;
      $display("FAIL max_sll_hold: data=%h expected 80000000", data_out);
    end
  endtask

  task automatic test_handshake();
    int n;
    exp_t e;
    start(32'h0000_0005, 6, 1'b0);
    // Stray strobe with different operands while shifting must change nothing
    @(negedge clock);
    ctrl_shift = 1'b1;
    data_in    = 32'h1234_5678;
    shamt      = 5'd1;
    @(negedge clock);
    ctrl_shift = 1'b0;
    total = total + 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy: busy=%b expected 1", busy); end
    n = 0;
    while (data_resultRDY !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    // Back-to-back start in the DONE cycle
    ctrl_shift = 1'b1;
    data_in    = 32'h0000_0003;
    shamt      = 5'd1;
    op         = 1'b0;
    e.data     = 32'h0000_0006;
    e.cyc      = cyc + 2;
    exp_q.push_back(e);
    @(negedge clock);
    ctrl_shift = 1'b0;
    wait_done();
  endtask

  task automatic test_reset_abort();
    start(32'h0000_1234, 10, 1'b0);
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    total = total + 1;
    if (data_out !== '0 || busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      bad++;
      $display("FAIL abort_outputs: data=%h busy=%b rdy=%b expected all 0", data_out, busy, data_resultRDY);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      total = total + 1;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_quiet: cycle %0d rdy=%b busy=%b expected 0 0", i, data_resultRDY, busy);
      end
    end
    start(32'h0000_00A5, 2, 1'b0);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_sll();
    test_zero();
    test_sra();
    test_max_sll();
    test_handshake();
    test_reset_abort();
    repeat (3) @(negedge clock);
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d results outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
